signal_offset_pipe: RTL and testbench

Parametrised, pipelined, multi-channel converter from signed ADC/DSP samples to offset-binary codes for the DAC-side signal source path. Each channel adds a programmable offset to a two's-complement or sign-magnitude input, clamps to the unsigned output range and flags saturation. A valid/ready handshake carries the samples, and per-channel saturation counters are kept for the host. It supersedes the fixed 12-bit, single-channel, combinational offset converter.

---
 rtl/signal_move_pkg.sv | 43 ++++
 rtl/signal_offset_lane.sv | 79 +++++++
 rtl/signal_offset_pipe.sv | 92 +++++++++
 tb/tb_signal_offset_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/signal_move_pkg.sv
// signal_move_pkg: shared definitions for the offset-binary sample pipeline.
//   - input mode codes (two's complement, sign-magnitude, bypass)
//   - default_offset(): mid-scale-minus-one offset for a given sample width
//   - clamp_sum(): clamps a signed offset sum into the unsigned W-bit range
package signal_move_pkg;

  localparam logic [1:0] MODE_TC  = 2'b00;
  localparam logic [1:0] MODE_SM  = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;

  // Widest supported sample; clamp_sum works at this width for every W.
  localparam int unsigned MAX_W = 24;

  typedef logic signed [MAX_W+1:0] wide_t;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] val;
  } clamp_t;

  function automatic int unsigned default_offset(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Bits of val above w are always zero.
  function automatic clamp_t clamp_sum(input wide_t r, input int unsigned w);
    wide_t  hi;
    clamp_t res;
    hi = wide_t'((64'd1 << w) - 64'd1);
    if (r < 0) begin
      res.sat = 1'b1;
      res.val = '0;
    end else if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi[MAX_W-1:0];
    end else begin
      res.sat = 1'b0;
      res.val = r[MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/signal_offset_lane.sv
// signal_offset_lane: single-channel datapath, three register stages.
//   clk, rst  : clock, asynchronous active-low reset
//   en        : pipeline advance enable shared by all lanes
//   sm        : beat at the input is sign-magnitude (else two's complement)
//   byp       : beat currently in stage 2 is a bypass beat
//   sigin     : raw input sample
//   sigout    : registered offset-binary result
//   sat       : registered clamp indicator aligned with sigout
module signal_offset_lane
  import signal_move_pkg::*;
#(
  parameter int unsigned W      = 12,
  parameter int unsigned OFFSET = default_offset(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sm,
  input  logic         byp,
  input  logic [W-1:0] sigin,
  output logic [W-1:0] sigout,
  output logic         sat
);

  localparam logic [W-1:0] OFF = OFFSET[W-1:0];

  logic        [W:0]   mag;
  logic signed [W:0]   dec;
  logic signed [W:0]   v1_q;
  logic        [W-1:0] raw1_q;
  logic signed [W+1:0] sum_d;
  logic signed [W+1:0] sum2_q;
  logic        [W-1:0] raw2_q;
  clamp_t              cl;
  logic        [W-1:0] out_d;
  logic                sat_d;

  // Decode; sign-magnitude negative zero naturally yields 0.
  always_comb begin
    mag = {2'b00, sigin[W-2:0]};
    if (sm) begin
      dec = sigin[W-1] ? -$signed(mag) : $signed(mag);
    end else begin
      dec = $signed({sigin[W-1], sigin});
    end
  end

  assign sum_d = $signed({v1_q[W], v1_q}) + $signed({2'b00, OFF});

  always_comb begin
    cl    = clamp_sum(wide_t'(sum2_q), W);
    out_d = byp ? raw2_q : cl.val[W-1:0];
    sat_d = ~byp & cl.sat;
  end

  if (W < MAX_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^cl.val[MAX_W-1:W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q   <= '0;
      raw1_q <= '0;
      sum2_q <= '0;
      raw2_q <= '0;
      sigout <= '0;
      sat    <= 1'b0;
    end else if (en) begin
      v1_q   <= dec;
      raw1_q <= sigin;
      sum2_q <= sum_d;
      raw2_q <= raw1_q;
      sigout <= out_d;
      sat    <= sat_d;
    end
  end

endmodule

// File: rtl/signal_offset_pipe.sv
// signal_offset_pipe: multi-channel signed-to-offset-binary converter.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake; mode sampled with each beat
//   sigin               : CH packed W-bit samples
//   out_valid/out_ready : output handshake
//   sigout, sat_flag    : packed results and per-channel clamp flags
//   sat_clr             : synchronous clear of all saturation counters
//   sat_cnt             : CH packed CNT_W-bit saturation counters
module signal_offset_pipe
  import signal_move_pkg::*;
#(
  parameter int unsigned W      = 12,
  parameter int unsigned CH     = 1,
  parameter int unsigned OFFSET = default_offset(W),
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [CH*W-1:0]   sigin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH*W-1:0]   sigout,
  output logic [CH-1:0]     sat_flag,
  input  logic              sat_clr,
  output logic [CH*CNT_W-1:0] sat_cnt
);

  logic en;
  logic fire;
  logic in_sm;
  logic in_byp;
  logic v1_q, v2_q;
  logic byp1_q, byp2_q;

  // Bubbles advance while out_valid is low; everything holds on a stall.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign fire     = out_valid & out_ready;
  assign in_sm    = (mode == MODE_SM);
  assign in_byp   = (mode & MODE_BYP) == MODE_BYP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      byp1_q    <= 1'b0;
      byp2_q    <= 1'b0;
    end else if (en) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      out_valid <= v2_q;
      byp1_q    <= in_byp;
      byp2_q    <= byp1_q;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;

    signal_offset_lane #(
      .W      (W),
      .OFFSET (OFFSET)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .sm     (in_sm),
      .byp    (byp2_q),
      .sigin  (sigin[k*W +: W]),
      .sigout (sigout[k*W +: W]),
      .sat    (sat_flag[k])
    );

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else if (sat_clr) begin
        cnt_q <= '0;
      end else if (fire && sat_flag[k] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign sat_cnt[k*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_signal_offset_pipe.sv
module tb_signal_offset_pipe;

  localparam int unsigned W     = 12;
  localparam int unsigned CH    = 2;
  localparam int unsigned CNT_W = 16;
  localparam int          NV    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst       = 1'b1;
  logic                 in_valid  = 1'b0;
  logic                 out_ready = 1'b1;
  logic                 sat_clr   = 1'b0;
  logic [1:0]           mode      = 2'b00;
  logic [CH*W-1:0]      sigin     = '0;
  logic                 in_ready, out_valid;
  logic [CH*W-1:0]      sigout;
  logic [CH-1:0]        sat_flag;
  logic [CH*CNT_W-1:0]  sat_cnt;

  logic                 b_valid = 1'b0;
  logic [W-1:0]         b_sigin = '0;
  logic                 b_ready, b_out_valid, b_sat;
  logic [W-1:0]         b_sigout;
  logic [CNT_W-1:0]     b_cnt;

  int checks = 0;
  int errors = 0;

  signal_offset_pipe #(.W(W), .CH(CH), .OFFSET(2047), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .sigin(sigin), .out_valid(out_valid), .out_ready(out_ready), .sigout(sigout),
    .sat_flag(sat_flag), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  signal_offset_pipe #(.W(W), .CH(1), .OFFSET(4095), .CNT_W(CNT_W)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .mode(mode),
    .sigin(b_sigin), .out_valid(b_out_valid), .out_ready(out_ready), .sigout(b_sigout),
    .sat_flag(b_sat), .sat_clr(sat_clr), .sat_cnt(b_cnt)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] in0, in1, exp0, exp1;
    logic        sat0, sat1;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ecnt0, ecnt1;
    logic [23:0] held;
    logic        stalled;
    int          sent, got;

    vecs[0] = '{2'b00, 12'h000, 12'h7FF, 12'h7FF, 12'hFFE, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 12'hFFF, 12'h800, 12'h7FE, 12'h000, 1'b0, 1'b1};
    vecs[2] = '{2'b01, 12'h801, 12'h800, 12'h7FE, 12'h7FF, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 12'hFFF, 12'h001, 12'h000, 12'h800, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 12'h800, 12'h123, 12'h800, 12'h123, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 1'b0, 1'b0};
    vecs[6] = '{2'b00, 12'h7FF, 12'h801, 12'hFFE, 12'h000, 1'b0, 1'b0};
    vecs[7] = '{2'b00, 12'h800, 12'h801, 12'h000, 12'h000, 1'b1, 1'b0};

    // Reset state
    #1 rst = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sigout", 64'(sigout), 64'd0);
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // OFFSET = 4095 instance: 0x7FF clamps high, counter +1
    b_valid = 1'b1;
    b_sigin = 12'h7FF;
    step();
    b_valid = 1'b0;
    step();
    check("b_latency_early", 64'(b_out_valid), 64'd0);
    step();
    check("b_out_valid", 64'(b_out_valid), 64'd1);
    check("b_sigout", 64'(b_sigout), 64'hFFF);
    check("b_sat", 64'(b_sat), 64'd1);
    step();
    check("b_cnt", 64'(b_cnt), 64'd1);

    // Table vectors, back to back, out_ready = 1
    ecnt0 = '0;
    ecnt1 = '0;
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) begin
        in_valid = 1'b1;
        mode     = vecs[c].mode;
        sigin    = {vecs[c].in1, vecs[c].in0};
      end else begin
        in_valid = 1'b0;
      end
      step();
      check("vec_in_ready", 64'(in_ready), 64'd1);
      if (c >= 2) begin
        check($sformatf("vec%0d_valid", c - 2), 64'(out_valid), 64'd1);
        check($sformatf("vec%0d_sigout", c - 2), 64'(sigout),
              64'({vecs[c-2].exp1, vecs[c-2].exp0}));
        check($sformatf("vec%0d_sat", c - 2), 64'(sat_flag),
              64'({vecs[c-2].sat1, vecs[c-2].sat0}));
        ecnt0 += 16'(vecs[c-2].sat0);
        ecnt1 += 16'(vecs[c-2].sat1);
      end
    end
    step();
    check("vec_drained", 64'(out_valid), 64'd0);
    check("vec_sat_cnt", 64'(sat_cnt), 64'({ecnt1, ecnt0}));

    // Backpressure: 10 beats, out_ready low for 5 cycles mid-stream
    mode    = 2'b00;
    sent    = 0;
    got     = 0;
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      in_valid  = (sent < 10);
      sigin     = {12'(12'hFF0 + sent), 12'(sent * 5)};
      out_ready = !(c >= 6 && c < 11);
      #1;
      if (stalled) begin
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_sigout", 64'(sigout), 64'(held));
      end
      if (out_valid && !out_ready) check("bp_in_ready_drop", 64'(in_ready), 64'd0);
      else check("bp_in_ready", 64'(in_ready), 64'd1);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check($sformatf("bp_beat%0d", got), 64'(sigout),
              64'({12'(2031 + got), 12'(got * 5 + 2047)}));
        check("bp_sat", 64'(sat_flag), 64'd0);
        got++;
      end
      stalled = out_valid & ~out_ready;
      held    = sigout;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 64'(got), 64'd10);

    // Counter saturation at all-ones
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("clr_cnt", 64'(sat_cnt), 64'd0);
    sigin    = {12'h800, 12'h800};
    in_valid = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step();
    in_valid = 1'b0;
    repeat (3) step();
    check("cnt_stick", 64'(sat_cnt), 64'hFFFF_FFFF);

    // Clear coincident with an increment
    in_valid = 1'b1;
    repeat (3) step();
    check("coll_valid", 64'(out_valid), 64'd1);
    check("coll_sat", 64'(sat_flag), 64'd3);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("coll_clr_wins", 64'(sat_cnt), 64'd0);
    step();
    check("coll_next_inc", 64'(sat_cnt), 64'h0001_0001);

    // Asynchronous reset with beats in flight
    sigin = {12'h010, 12'h020};
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_sigout", 64'(sigout), 64'd0);
    check("arst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("arst_no_stale", 64'(out_valid), 64'd0);
    end

    // First beat after release: visible on the third edge from acceptance
    in_valid = 1'b1;
    sigin    = {12'h001, 12'h002};
    check("rel_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    step();
    check("rel_early", 64'(out_valid), 64'd0);
    step();
    check("rel_valid", 64'(out_valid), 64'd1);
    check("rel_sigout", 64'(sigout), 64'({12'h800, 12'h801}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
